// File: rtl/ext_sleep_ctl_pkg.sv
// Shared constants for the external sleep-request front end.
// State encodings, default parameter values and interrupt count.
// Imported by ext_sleep_ctl and sync_filt.
package ext_sleep_ctl_pkg;

   localparam int ESC_SYNC_STAGES_DEF = 2;
   localparam int ESC_FILT_LEN_DEF    = 8;
   localparam int ESC_REQ_TMO_DEF     = 200;
   localparam int INT_COUNT           = 6;
   // Wide enough for FILT_LEN up to 15.
   localparam int ESC_CNT_W           = 4;

   typedef enum logic [1:0] {
      ESC_ST_AWAKE  = 2'd0,
      ESC_ST_REQ    = 2'd1,
      ESC_ST_ASLEEP = 2'd2,
      ESC_ST_WAKE   = 2'd3
   } esc_state_e;

endpackage

// File: rtl/ext_sleep_ctl_sync.sv
// Synchroniser + per-pin glitch filter + bypass mux for one async pin.
// Latency: SYNC_STAGES cycles to the sync output, FILT_LEN more to flip the filter (combinational out).
// No backpressure; level signal, changes only after FILT_LEN consecutive mismatching cycles.
module sync_filt
   import ext_sleep_ctl_pkg::*;
#(
   parameter int   SYNC_STAGES = ESC_SYNC_STAGES_DEF,
   parameter int   FILT_LEN    = ESC_FILT_LEN_DEF,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic bypass,
   input  logic pin,
   output logic lvl
);

   localparam logic [ESC_CNT_W-1:0] CNT_LAST = ESC_CNT_W'(FILT_LEN - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_out;
   logic                   bypass_q;
   logic                   filt;
   logic [ESC_CNT_W-1:0]   cnt;

   assign sync_out = sync[SYNC_STAGES-1];

   // Shift the async pin through the synchroniser chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= {SYNC_STAGES{RST_VAL}};
      else     sync <= {sync[SYNC_STAGES-2:0], pin};
   end

   // Remember the previous bypass setting so a toggle can be detected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) bypass_q <= 1'b0;
      else     bypass_q <= bypass;
   end

   // Filter: count consecutive mismatches, flip after FILT_LEN of them.
   // While bypassed the filtered level shadows the sync output so that
   // leaving bypass does not produce a stale-level glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt <= RST_VAL;
         cnt  <= '0;
      end else if (bypass || (bypass != bypass_q)) begin
         filt <= sync_out;
         cnt  <= '0;
      end else if (sync_out == filt) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         filt <= ~filt;
         cnt  <= '0;
      end else if (cnt != '1) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign lvl = bypass ? sync_out : filt;

endmodule

// File: rtl/ext_sleep_ctl.sv
// Sleep-request front end: filters pin + 6 interrupts, runs REQ/ACK handshake FSM.
// Latency: pin edge to output SYNC_STAGES+FILT_LEN+1 cycles (SYNC_STAGES+1 in bypass).
// No backpressure; request aborts after REQ_TMO cycles without core frozen.
module ext_sleep_ctl
   import ext_sleep_ctl_pkg::*;
#(
   parameter int SYNC_STAGES = ESC_SYNC_STAGES_DEF,
   parameter int FILT_LEN    = ESC_FILT_LEN_DEF,
   parameter int REQ_TMO     = ESC_REQ_TMO_DEF
) (
   input  logic                 SYSCLKF,
   input  logic                 RESET_D1_R,
   input  logic                 CFG_FILT_BYPASS,
   input  logic                 EXT_SLEEPREQ_PIN,
   input  logic [INT_COUNT-1:0] EXT_INTREQ_PIN_N,
   input  logic                 SL_HALT_ANY_R,
   input  logic                 SL_SLEEPSYS_C0_R,
   output logic                 EXT_SLEEPREQ_R,
   output logic [INT_COUNT-1:0] INTREQ_N,
   output logic                 EXT_SLEEPACK_R,
   output logic                 EXT_SLEEPERR_R
);

   localparam logic [7:0] TMO_LAST = 8'(REQ_TMO - 1);

   logic                 freq;
   logic [INT_COUNT-1:0] int_lvl;
   esc_state_e           state;
   esc_state_e           nxt;
   logic                 tmo_hit;
   logic [7:0]           tmo;

   sync_filt #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .RST_VAL     (1'b0)
   ) u_req_filt (
      .clk    (SYSCLKF),
      .rst    (RESET_D1_R),
      .bypass (CFG_FILT_BYPASS),
      .pin    (EXT_SLEEPREQ_PIN),
      .lvl    (freq)
   );

   for (genvar i = 0; i < INT_COUNT; i++) begin : g_int
      sync_filt #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_LEN    (FILT_LEN),
         .RST_VAL     (1'b1)
      ) u_int_filt (
         .clk    (SYSCLKF),
         .rst    (RESET_D1_R),
         .bypass (CFG_FILT_BYPASS),
         .pin    (EXT_INTREQ_PIN_N[i]),
         .lvl    (int_lvl[i])
      );
   end

   // Interrupts pass straight through a register; no handshake gating.
   always_ff @(posedge SYSCLKF or posedge RESET_D1_R) begin
      if (RESET_D1_R) INTREQ_N <= {INT_COUNT{1'b1}};
      else            INTREQ_N <= int_lvl;
   end

   // Timeout counter: zero outside ST_REQ, so every entry starts from 0.
   always_ff @(posedge SYSCLKF or posedge RESET_D1_R) begin
      if (RESET_D1_R)              tmo <= '0;
      else if (state != ESC_ST_REQ) tmo <= '0;
      else if (tmo != 8'hFF)       tmo <= tmo + 8'd1;
   end

   // Next-state logic; within ST_REQ sleep beats drop beats timeout.
   always_comb begin
      nxt     = state;
      tmo_hit = 1'b0;
      case (state)
         ESC_ST_AWAKE: begin
            if (freq) nxt = ESC_ST_REQ;
         end
         ESC_ST_REQ: begin
            if (SL_SLEEPSYS_C0_R) begin
               nxt = ESC_ST_ASLEEP;
            end else if (!freq) begin
               nxt = ESC_ST_WAKE;
            end else if (tmo == TMO_LAST) begin
               nxt     = ESC_ST_WAKE;
               tmo_hit = 1'b1;
            end
         end
         ESC_ST_ASLEEP: begin
            if (!freq || !SL_SLEEPSYS_C0_R) nxt = ESC_ST_WAKE;
         end
         ESC_ST_WAKE: begin
            // Request is ignored here; it is only seen again from ST_AWAKE.
            if (!SL_SLEEPSYS_C0_R && !SL_HALT_ANY_R) nxt = ESC_ST_AWAKE;
         end
         default: nxt = ESC_ST_AWAKE;
      endcase
   end

   // State register plus outputs decoded from the next state.
   // ASLEEP is only reachable from REQ, so ACK always follows a REQ cycle.
   always_ff @(posedge SYSCLKF or posedge RESET_D1_R) begin
      if (RESET_D1_R) begin
         state          <= ESC_ST_AWAKE;
         EXT_SLEEPREQ_R <= 1'b0;
         EXT_SLEEPACK_R <= 1'b0;
         EXT_SLEEPERR_R <= 1'b0;
      end else begin
         state          <= nxt;
         EXT_SLEEPREQ_R <= (nxt == ESC_ST_REQ) || (nxt == ESC_ST_ASLEEP);
         EXT_SLEEPACK_R <= (nxt == ESC_ST_ASLEEP);
         EXT_SLEEPERR_R <= tmo_hit;
      end
   end

endmodule
